// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box definitions: state geometry, engine FSM encoding,
// FIPS-197 forward/inverse substitution tables and a lookup helper.
package aes_sbox_pkg;

    localparam int STATE_W   = 128;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 16;

    // Byte-addressable view of a state: element 0 is the most significant byte.
    typedef logic [0:NUM_BYTES-1][BYTE_W-1:0] state_t;

    // Engine FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Forward S-box, entry 0 first.
    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, entry 0 first.
    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Substitute one byte through the forward or inverse table.
    function automatic logic [BYTE_W-1:0] sbox_lookup(input logic [BYTE_W-1:0] b,
                                                       input logic inverse);
        return inverse ? SBOX_INV[b] : SBOX_FWD[b];
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane shared between forward and inverse mode.
module sbox_lane
    import aes_sbox_pkg::*;
(
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              inverse,
    output logic [BYTE_W-1:0] out_byte
);

    // Table lookup selected by mode.
    always_comb begin
        out_byte = sbox_lookup(in_byte, inverse);
    end

endmodule

// File: rtl/sbox_sub_engine.sv
// Sequential SubBytes/InvSubBytes engine: substitutes LANES bytes of a
// 128-bit state per clock, with valid/ready handshakes and a flush.
module sbox_sub_engine
    import aes_sbox_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inverse,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam int BEATS = NUM_BYTES / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sbox_sub_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]       fsm_q,   fsm_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             mode_q,  mode_d;
    state_t           state_q, state_d;

    logic [BYTE_W-1:0] lane_in  [LANES];
    logic [BYTE_W-1:0] lane_out [LANES];

    // Route the bytes of the current beat's slot to the lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = state_q[4'(int'(cnt_q) * LANES + l)];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_lane u_lane (
            .in_byte  (lane_in[g]),
            .inverse  (mode_q),
            .out_byte (lane_out[g])
        );
    end

    // Next-state logic: flush overrides everything, then accept/run/drain.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        state_d = state_q;
        if (flush) begin
            fsm_d = ST_IDLE;
            cnt_d = '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_d = in_state;
                        mode_d  = in_inverse;
                        cnt_d   = '0;
                        fsm_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        state_d[4'(int'(cnt_q) * LANES + l)] = lane_out[l];
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        fsm_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_d = ST_IDLE;
                    end
                end
                default: begin
                    fsm_d = ST_IDLE;
                    cnt_d = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            state_q <= state_d;
        end
    end

    // Handshake and status outputs decoded from the FSM.
    always_comb begin
        in_ready  = (fsm_q == ST_IDLE);
        out_valid = (fsm_q == ST_DONE);
        busy      = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
        out_state = state_q;
    end

endmodule

// File: doc/sbox_sub_engine.md
Name: sbox_sub_engine

Overview:
- Parametrised, sequential AES SubBytes/InvSubBytes unit for a full 128-bit state, used by both the encryption and decryption round datapaths.
- Processes LANES bytes per clock through LANES shared forward/inverse S-box lanes, trading area against latency.
- Per-transaction mode select (forward or inverse).
- Valid/ready handshakes on input and output, plus a synchronous flush.

Parameters:
- LANES, 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- BEATS, 16/LANES: derived localparam; number of RUN cycles per state.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  input state is valid.
- in_ready  out  1  block can accept a state.
- in_inverse  in  1  0 = forward S-box, 1 = inverse S-box; sampled at accept.
- in_state  in  128  input state; byte 0 = [127:120], byte 15 = [7:0].
- out_valid  out  1  out_state is valid.
- out_ready  in  1  consumer accepts out_state.
- out_state  out  128  substituted state, same byte order as in_state.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, beat counter=0, mode reg=0, state reg=0. Outputs: in_ready=1, out_valid=0, busy=0, out_state=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (accept edge), in_state is latched into the state reg, in_inverse into the mode reg, the counter is set to 0, and FSM goes to RUN.
- RUN:
  - in_ready=0.
  - Each edge replaces bytes [cnt*LANES .. cnt*LANES+LANES-1] of the state reg with S(byte), or S^-1(byte) when the mode reg is 1. All other bytes are held.
  - cnt increments each edge. On the edge where cnt=BEATS-1, cnt wraps to 0 and FSM goes to DONE.
- DONE:
  - out_valid=1, out_state=state reg, held stable while out_ready=0.
  - On out_valid&out_ready the FSM goes to IDLE. in_ready stays 0 during DONE, so there is no same-cycle re-accept.
- Latency: accept in cycle 0; out_valid is first high in cycle BEATS+1.
  - LANES=16: cycle 2. LANES=4: cycle 5. LANES=1: cycle 17.
- Throughput: one state per BEATS+2 cycles, assuming out_ready=1 as soon as out_valid rises.
- out_state may show partial results during RUN. Consumers use it only when out_valid=1.
- flush:
  - Highest synchronous priority. From any state, the next edge gives FSM=IDLE, cnt=0, out_valid=0.
  - The in-flight state is discarded; the state reg is not cleared.
  - flush together with out_ready in DONE is a flush; no transfer is counted.
  - flush in IDLE together with in_valid: no accept.
- rst asserted mid-RUN/DONE: immediate return to reset values. The first accept after rst deasserts behaves like a fresh start.
- in_inverse and in_state changing during RUN have no effect.
- S-box contents are exactly FIPS-197 Fig. 7 (forward) and Fig. 14 (inverse), all 256 entries defined, no X outputs. Spot values:
  - S(00)=63, S(53)=ED, S(FF)=16.
  - S^-1(63)=00, S^-1(00)=52, S^-1(FF)=7D.
- Purely byte-wise: no carries or width growth; all lanes are independent.

Decomposition:
- Package aes_sbox_pkg:
  - STATE_W=128, BYTE_W=8, NUM_BYTES=16.
  - FSM state encoding (IDLE/RUN/DONE).
  - Forward and inverse 256x8 S-box constant tables.
  - Function sbox_lookup(byte, inverse).
- Sub-module sbox_lane: combinational 8-bit in, inverse select, 8-bit out, built from the package tables. LANES instances are generated in the engine. The standalone inverse S-box is superseded by this lane.
- Engine holds only FSM, counter, mode/state registers and byte-slot muxing.

Test Plan:
- FIPS-197 Appendix B round 1, forward, LANES=4: in_state 193DE3BEA0F4E22B9AC68D2AE9F84808 → out_state D42711AEE0BF98F1B8B45DE51E415230 with out_valid first high in cycle 5.
- Same vector inverse: in_state D42711AEE0BF98F1B8B45DE51E415230, in_inverse=1 → 193DE3BEA0F4E22B9AC68D2AE9F84808.
- Exhaustive table check at LANES=16 (latency 2):
  - Sweep states whose bytes are k..k+15 for k=0,16,...,240 in both modes; compare against the golden model.
  - Explicitly check that inverse of all-FF gives all-7D and that forward of all-00 gives all-63.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid, out_state and in_ready=0 all stable; out_ready=1 → IDLE next edge, in_ready=1.
- Flush at cycle 2 of RUN (LANES=1) → out_valid never asserts, in_ready=1 after the flush edge. The next state 00..00 forward gives 63..63.
- Async rst pulse mid-RUN between clock edges → outputs take reset values immediately without a clock edge; a following transaction is correct.
- Parameter sweep LANES ∈ {1,2,8} with the Appendix B vector → same result, latency BEATS+1.
